// File: rtl/jk_bank_driver.sv
// Drives the J/K inputs of an external JK flip-flop bank toward a requested target word,
// verifies the bank via Q feedback and retries on mismatch. Define JK_TOGGLE_EN for toggle-code excitation.
module jk_bank_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] j_d, k_d;
  logic             done_d, err_d;
  logic [WIDTH-1:0] exc_src, exc_j, exc_k;

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Excitation source is the incoming word at capture, the held target on retry.
  assign exc_src = (state_q == IDLE) ? tgt_data : tgt_q;

`ifdef JK_TOGGLE_EN
  assign exc_j = exc_src ^ q_fb;
  assign exc_k = exc_src ^ q_fb;
`else
  assign exc_j = exc_src & ~q_fb;
  assign exc_k = ~exc_src & q_fb;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      retry_q <= '0;
      j       <= '0;
      k       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      j       <= j_d;
      k       <= k_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          j_d     = exc_j;
          k_d     = exc_k;
          retry_d = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural JK bank model and a result scoreboard.
module tb_jk_bank_driver;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_RETRY = 3;

  typedef struct {
    logic       is_err;
    logic [7:0] q;
    int         cycles;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic             clk;
  logic             reset;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;

  logic [7:0] bank;
  logic [7:0] stuck0;
  logic [7:0] preset_val;
  logic       preset_en;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: 10 set, 01 reset, 11 toggle, 00 hold; stuck0 bits always read back 0.
  always @(posedge clk) begin
    if (preset_en) bank <= preset_val;
    else           bank <= (j & ~k) | (~j & ~k & bank) | (j & k & ~bank);
  end
  assign q_fb = bank & ~stuck0;

  function automatic logic [7:0] exp_j(input logic [7:0] t, input logic [7:0] q);
`ifdef JK_TOGGLE_EN
    return t ^ q;
`else
    return t & ~q;
`endif
  endfunction

  function automatic logic [7:0] exp_k(input logic [7:0] t, input logic [7:0] q);
`ifdef JK_TOGGLE_EN
    return t ^ q;
`else
    return ~t & q;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic preset(input logic [7:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input int cycles);
    exp_t e;
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_done"},   32'(done),       32'(!e.is_err));
      chk({tag, "_err"},    32'(err),        32'(e.is_err));
      chk({tag, "_q"},      32'(q_fb),       32'(e.q));
      chk({tag, "_cycles"}, 32'(cycles),     32'(e.cycles));
      chk({tag, "_ready"},  32'(tgt_ready),  32'd1);
    end
  endtask

  // Called one cycle into DRIVE; follows CHECK/DRIVE alternation until a result pulse.
  task automatic wait_result(input string tag, input logic [7:0] tgt, input logic [7:0] q_start);
    logic [7:0] q_prev;
    bit         found;
    q_prev = q_start;
    found  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done || err) begin
        pop_check(tag, i);
        found = 1'b1;
        break;
      end
      if (i % 2 == 0) begin
        chk({tag, "_rj"}, 32'(j), 32'(exp_j(tgt, q_prev)));
        chk({tag, "_rk"}, 32'(k), 32'(exp_k(tgt, q_prev)));
      end else begin
        q_prev = q_fb;
      end
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL %s_timeout observed=no_pulse expected=pulse", tag);
    end
  endtask

  task automatic run_txn(input string tag, input logic [7:0] tgt, input logic is_err, input int retries);
    logic [7:0] q0;
    q0 = q_fb;
    sb.push_back('{is_err, is_err ? (tgt & ~stuck0) : tgt, 2 + 2 * retries});
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_data  = 8'hFF;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_j"},    32'(j),    32'(exp_j(tgt, q0)));
    chk({tag, "_k"},    32'(k),    32'(exp_k(tgt, q0)));
    wait_result(tag, tgt, q0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_err_1cyc"},  32'(err),  32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_data   = 8'h00;
    stuck0     = 8'h00;
    preset_val = 8'h00;
    preset_en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_j",     32'(j),         32'd0);
    chk("rst_k",     32'(k),         32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ready", 32'(tgt_ready), 32'd1);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    reset     = 1'b1;
    preset_en = 1'b0;

    // Set path straight out of reset (bank = 0x00).
    run_txn("set", 8'hA5, 1'b0, 0);

    preset(8'hFF);
    run_txn("rstpath", 8'h0F, 1'b0, 0);

    preset(8'h3C);
    run_txn("nochg", 8'h3C, 1'b0, 0);

    // Bit 0 never reads back high: all retries fail.
    preset(8'h00);
    stuck0 = 8'h01;
    run_txn("stuck", 8'h01, 1'b1, int'(MAX_RETRY));
    stuck0 = 8'h00;

    // Asynchronous reset in the middle of DRIVE.
    preset(8'h00);
    tgt_valid = 1'b1;
    tgt_data  = 8'h5A;
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("mid_j_pre", 32'(j), 32'(exp_j(8'h5A, 8'h00)));
    #2 reset = 1'b0;
    #1;
    chk("mid_j",     32'(j),         32'd0);
    chk("mid_k",     32'(k),         32'd0);
    chk("mid_busy",  32'(busy),      32'd0);
    chk("mid_ready", 32'(tgt_ready), 32'd1);
    @(negedge clk);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err",  32'(err),  32'd0);
    @(negedge clk);
    chk("mid_done2", 32'(done), 32'd0);
    chk("mid_err2",  32'(err),  32'd0);
    reset = 1'b1;

    // Back-to-back with tgt_valid held high.
    preset(8'h00);
    sb.push_back('{1'b0, 8'h11, 2});
    sb.push_back('{1'b0, 8'h22, 2});
    tgt_valid = 1'b1;
    tgt_data  = 8'h11;
    @(negedge clk);
    tgt_data  = 8'h22;
    chk("b2b_a_j", 32'(j), 32'(exp_j(8'h11, 8'h00)));
    chk("b2b_a_k", 32'(k), 32'(exp_k(8'h11, 8'h00)));
    wait_result("b2b_a", 8'h11, 8'h00);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("b2b_b_busy", 32'(busy), 32'd1);
    chk("b2b_b_done_low", 32'(done), 32'd0);
    chk("b2b_b_j", 32'(j), 32'(exp_j(8'h22, 8'h11)));
    chk("b2b_b_k", 32'(k), 32'(exp_k(8'h22, 8'h11)));
    wait_result("b2b_b", 8'h22, 8'h11);
    @(negedge clk);
    chk("b2b_bank",  32'(q_fb), 32'h22);
    chk("b2b_idle",  32'(busy), 32'd0);
    chk("sb_empty",  32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
